comparator_sweep_tester: RTL

COMPARATOR_SWEEP_TESTER -- requirements
Module: comparator_sweep_tester

---
 rtl/comparator_pkg.sv | 21 ++
 rtl/comparator_golden.sv | 30 +++
 rtl/comparator_sweep_tester.sv | 132 +++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator sweep tester: FSM encoding, vector space and field widths.
package comparator_pkg;

    localparam int OPERAND_W   = 4;
    localparam int VEC_W       = 2 * OPERAND_W + 1;
    localparam int NUM_VECTORS = 512;
    localparam int ERR_W       = 10;
    localparam int SETTLE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic [VEC_W-1:0] vec_t;

    localparam vec_t LAST_VEC = vec_t'(NUM_VECTORS - 1);

endpackage

// File: rtl/comparator_golden.sv
// Reference comparator: one-hot {equals, greater, less}, unsigned when sign=0, two's complement when sign=1.
module comparator_golden
    import comparator_pkg::*;
(
    input  logic                 sign,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 equals,
    output logic                 greater,
    output logic                 less
);

    logic signed [OPERAND_W-1:0] a_s;
    logic signed [OPERAND_W-1:0] b_s;

    assign a_s = $signed(a);
    assign b_s = $signed(b);

    always_comb begin
        equals = (a == b);
        if (sign) begin
            greater = (a_s > b_s);
            less    = (a_s < b_s);
        end else begin
            greater = (a > b);
            less    = (a < b);
        end
    end

endmodule

// File: rtl/comparator_sweep_tester.sv
// Exhaustive sweep of all {sign,A,B} vectors against an external comparator, counting mismatches
// against the golden model and latching the first failing vector.
module comparator_sweep_tester
    import comparator_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 sign_out,
    output logic [OPERAND_W-1:0] a_out,
    output logic [OPERAND_W-1:0] b_out,
    input  logic                 equals_in,
    input  logic                 greater_in,
    input  logic                 less_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 first_fail_valid,
    output logic [VEC_W-1:0]     first_fail_vec
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    // With no settle time each vector goes straight to its check cycle.
    localparam state_t SWEEP_ENTRY = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;

    state_t              state_q, state_d;
    vec_t                vec_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [ERR_W-1:0]    err_q;
    logic                ffv_q;
    vec_t                ffvec_q;

    logic gold_eq, gold_gt, gold_lt;
    logic start_take;
    logic mismatch;

    comparator_golden u_golden (
        .sign    (vec_q[VEC_W-1]),
        .a       (vec_q[2*OPERAND_W-1:OPERAND_W]),
        .b       (vec_q[OPERAND_W-1:0]),
        .equals  (gold_eq),
        .greater (gold_gt),
        .less    (gold_lt)
    );

    assign start_take = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
    assign mismatch   = (state_q == ST_CHECK) &&
                        ({equals_in, greater_in, less_in} != {gold_eq, gold_gt, gold_lt});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_take) state_d = SWEEP_ENTRY;
            end
            ST_SETTLE: begin
                if (abort)                 state_d = ST_IDLE;
                else if (settle_q == '0)   state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)                 state_d = ST_IDLE;
                else if (vec_q == LAST_VEC) state_d = ST_DONE;
                else                       state_d = SWEEP_ENTRY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        done = (state_q == ST_DONE);
        pass = (state_q == ST_DONE) && (err_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            settle_q <= '0;
        end else begin
            if (start_take) begin
                vec_q <= '0;
            end else if ((state_q == ST_CHECK) && !abort && (vec_q != LAST_VEC)) begin
                vec_q <= vec_q + vec_t'(1);
            end
            // Reload on every entry to SETTLE, count down while there.
            if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
                settle_q <= SETTLE_LOAD;
            end else if ((state_q == ST_SETTLE) && (settle_q != '0)) begin
                settle_q <= settle_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else if (start_take) begin
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else if (mismatch) begin
            err_q <= err_q + ERR_W'(1);
            if (!ffv_q) begin
                ffv_q   <= 1'b1;
                ffvec_q <= vec_q;
            end
        end
    end

    assign sign_out         = vec_q[VEC_W-1];
    assign a_out            = vec_q[2*OPERAND_W-1:OPERAND_W];
    assign b_out            = vec_q[OPERAND_W-1:0];
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
